// File: rtl/sd_sector_feeder_pkg.sv
// sd_sector_feeder_pkg: FSM states, sector sizing and bank count.
// Defining SD_FEEDER_PINGPONG_EN selects two ping-pong banks; otherwise one bank is used.
package sd_sector_feeder_pkg;
  localparam int SECTOR_WORDS = 256;
`ifdef SD_FEEDER_PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, STREAM, WAIT_DONE} state_t;
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [31:0] base, input logic [31:0] last);
    return (a == last) ? base : a + 32'd1;
  endfunction
endpackage

// File: rtl/sd_sector_feeder_if.sv
// sd_sector_feeder_if: producer word stream plus SPI sector-writer handshake.
interface sd_sector_feeder_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        wr_busy;
  logic        wr_req;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic        overflow;
  modport master (
    output in_valid, in_data, wr_busy, wr_req,
    input  in_ready, wr_start_en, wr_sec_addr, wr_data, overflow
  );
  modport slave (
    input  in_valid, in_data, wr_busy, wr_req,
    output in_ready, wr_start_en, wr_sec_addr, wr_data, overflow
  );
endinterface

// File: rtl/sd_sector_feeder_dpram.sv
// sd_feeder_dpram: simple dual-port RAM, one write port and one registered read port.
module sd_feeder_dpram #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk_sd,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk_sd)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk_sd or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (re) q <= mem[raddr];
endmodule

// File: rtl/sd_sector_feeder.sv
// sd_sector_feeder: buffers producer words into 256-word sectors and streams them to an SPI writer.
// SD_FEEDER_PINGPONG_EN (via the package) selects two banks instead of one.
module sd_sector_feeder
  import sd_sector_feeder_pkg::*;
#(
  parameter logic [31:0] SEC_ADDR_BASE = 32'd0,
  parameter logic [31:0] SEC_ADDR_LAST = 32'hFFFF_FFFF
) (
  input logic clk_sd,
  input logic reset_n,
  sd_sector_feeder_if.slave bus
);
  localparam logic PP = (BANKS == 2);
  state_t      state, state_n;
  logic [1:0]  full;
  logic        fill_bank, rd_bank;
  logic [7:0]  fill_idx;
  logic [8:0]  rd_cnt;
  logic [31:0] addr;
  logic        overflow_q, accept, wrap, load, free_bank;
  logic [15:0] rd_q;
  assign bus.in_ready    = !full[fill_bank];
  assign bus.wr_start_en = (state == START) || (state == WAIT_ACK);
  assign bus.wr_sec_addr = addr;
  assign bus.wr_data     = rd_q;
  assign bus.overflow    = overflow_q;
  assign accept = bus.in_valid && bus.in_ready;
  assign wrap   = accept && (fill_idx == 8'hFF);
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    free_bank = 1'b0;
    case (state)
      IDLE:      state_n = (full[rd_bank] && !bus.wr_busy) ? START : IDLE;
      START:     state_n = WAIT_ACK;
      WAIT_ACK:  state_n = bus.wr_busy ? STREAM : WAIT_ACK;
      STREAM: begin
        // a busy drop mid-stream is an abort: the bank stays full and is retried
        load    = bus.wr_busy && bus.wr_req && !rd_cnt[8];
        state_n = !bus.wr_busy ? IDLE : (load && rd_cnt == 9'd255) ? WAIT_DONE : STREAM;
      end
      WAIT_DONE: begin
        free_bank = !bus.wr_busy;
        state_n   = bus.wr_busy ? WAIT_DONE : IDLE;
      end
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sd or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      full       <= '0;
      fill_bank  <= 1'b0;
      rd_bank    <= 1'b0;
      fill_idx   <= '0;
      rd_cnt     <= '0;
      addr       <= SEC_ADDR_BASE;
      overflow_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) fill_idx <= fill_idx + 8'd1;
      if (wrap) fill_bank <= fill_bank ^ PP;
      // banks fill and drain in the same order, so the read pointer always names the oldest full bank
      for (int b = 0; b < 2; b++)
        full[b] <= (full[b] && !(free_bank && rd_bank == 1'(b))) || (wrap && fill_bank == 1'(b));
      if (state == START) rd_cnt <= '0;
      else if (load) rd_cnt <= rd_cnt + 9'd1;
      if (free_bank) begin
        rd_bank <= rd_bank ^ PP;
        addr    <= next_addr(addr, SEC_ADDR_BASE, SEC_ADDR_LAST);
      end
      if (bus.in_valid && !bus.in_ready) overflow_q <= 1'b1;
    end
  sd_feeder_dpram #(.AW(9), .DW(16)) u_ram (
    .clk_sd  (clk_sd),
    .reset_n (reset_n),
    .we      (accept),
    .waddr   ({fill_bank, fill_idx}),
    .wdata   (bus.in_data),
    .re      (load),
    .raddr   ({rd_bank, rd_cnt[7:0]}),
    .q       (rd_q)
  );
  assert property (@(posedge clk_sd) disable iff (!reset_n) !(free_bank && wrap && rd_bank == fill_bank));
endmodule
